// File: rtl/id_pkg.sv
// Shared definitions for the decode/issue stage: branch-type encoding,
// immediate-extension selectors and the hard-wired zero register index.
package id_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LEZ  = 3'd3,
    BR_GTZ  = 3'd4,
    BR_LTZ  = 3'd5,
    BR_GEZ  = 3'd6
  } br_t;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/gpr_file.sv
// General-purpose register file: two asynchronous read ports, one
// synchronous write port. Register 0 is never written.
// Optional macro ID_WB_BYPASS_EN makes the read ports write-through.
module gpr_file import id_pkg::*; #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic            wr_en;

  assign wr_en = we && (wa != AW'(REG_ZERO));

  // Next register-file contents: apply the single write, if any
  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wa] = wd;
  end

  // Register-file storage, cleared on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef ID_WB_BYPASS_EN
  // Write-through reads: a same-cycle write to the addressed register wins
  always_comb begin
    rd1 = (wr_en && (wa == ra1)) ? wd : regs_q[ra1];
    rd2 = (wr_en && (wa == ra2)) ? wd : regs_q[ra2];
  end
`else
  // Plain reads: a write becomes visible the cycle after it happens
  always_comb begin
    rd1 = regs_q[ra1];
    rd2 = regs_q[ra2];
  end
`endif

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage: register read with forwarding, load-use hazard stall,
// branch/jump resolution and a registered valid/ready bundle towards EX.
// Optional macro ID_WB_BYPASS_EN (in gpr_file) enables register write-through.
module id_issue_stage import id_pkg::*; #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned NFWD  = 2,
  parameter int unsigned CTRLW = 30,
  parameter int unsigned AW    = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [31:0]          in_instr,
  input  logic [1:0]           in_extop,
  input  logic [2:0]           in_br,
  input  logic                 in_jmp,
  input  logic                 in_jr,
  input  logic                 in_rs_use,
  input  logic                 in_rt_use,
  input  logic [CTRLW-1:0]     in_ctrl,
  input  logic                 wb_we,
  input  logic [AW-1:0]        wb_rw,
  input  logic [XLEN-1:0]      wb_wd,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD-1:0]      fwd_pending,
  input  logic [NFWD*AW-1:0]   fwd_rw,
  input  logic [NFWD*XLEN-1:0] fwd_wd,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [31:0]          out_instr,
  output logic [CTRLW-1:0]     out_ctrl,
  output logic [XLEN-1:0]      out_rd1,
  output logic [XLEN-1:0]      out_rd2,
  output logic [XLEN-1:0]      out_ext
);

  logic [AW-1:0]   rs_a, rt_a;
  logic [15:0]     imm;
  logic [XLEN-1:0] rf_rd1, rf_rd2;
  logic            rs_hit, rt_hit, rs_pend, rt_pend;
  logic [XLEN-1:0] rs_fwd, rt_fwd, rd1, rd2;
  logic [XLEN-1:0] imm_sext, ext, br_target, jmp_target;
  logic            hazard, fire, br_taken;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_pc_q, out_pc_d;
  logic [31:0]      out_instr_q, out_instr_d;
  logic [CTRLW-1:0] out_ctrl_q, out_ctrl_d;
  logic [XLEN-1:0]  out_rd1_q, out_rd1_d;
  logic [XLEN-1:0]  out_rd2_q, out_rd2_d;
  logic [XLEN-1:0]  out_ext_q, out_ext_d;

  assign rs_a = AW'(in_instr[25:21]);
  assign rt_a = AW'(in_instr[20:16]);
  assign imm  = in_instr[15:0];

  gpr_file #(
    .XLEN (XLEN),
    .NREG (NREG),
    .AW   (AW)
  ) u_gpr (
    .clk (clk),
    .rst (rst),
    .we  (wb_we),
    .wa  (wb_rw),
    .wd  (wb_wd),
    .ra1 (rs_a),
    .ra2 (rt_a),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2)
  );

  // Forward select: lowest-index matching port wins; hits on r0 are ignored
  always_comb begin
    rs_hit  = 1'b0;
    rt_hit  = 1'b0;
    rs_pend = 1'b0;
    rt_pend = 1'b0;
    rs_fwd  = '0;
    rt_fwd  = '0;
    for (int unsigned i = 0; i < NFWD; i++) begin
      if (!rs_hit && fwd_valid[i] && (fwd_rw[i*AW +: AW] == rs_a)
          && (rs_a != AW'(REG_ZERO))) begin
        rs_hit  = 1'b1;
        rs_pend = fwd_pending[i];
        rs_fwd  = fwd_wd[i*XLEN +: XLEN];
      end
      if (!rt_hit && fwd_valid[i] && (fwd_rw[i*AW +: AW] == rt_a)
          && (rt_a != AW'(REG_ZERO))) begin
        rt_hit  = 1'b1;
        rt_pend = fwd_pending[i];
        rt_fwd  = fwd_wd[i*XLEN +: XLEN];
      end
    end
    rd1 = (rs_a == AW'(REG_ZERO)) ? '0 : (rs_hit ? rs_fwd : rf_rd1);
    rd2 = (rt_a == AW'(REG_ZERO)) ? '0 : (rt_hit ? rt_fwd : rf_rd2);
  end

  assign hazard   = in_valid && ((in_rs_use && rs_hit && rs_pend) ||
                                 (in_rt_use && rt_hit && rt_pend));
  assign in_ready = !hazard && (!out_valid_q || out_ready);
  assign fire     = in_valid && in_ready && !flush;

  // Immediate extension and branch/jump target generation
  always_comb begin
    imm_sext = {{(XLEN-16){imm[15]}}, imm};
    case (in_extop)
      EXT_ZERO: ext = {{(XLEN-16){1'b0}}, imm};
      EXT_SIGN: ext = imm_sext;
      EXT_LUI:  ext = XLEN'({imm, 16'h0000});
      default:  ext = '0;
    endcase
    br_target  = in_pc + {imm_sext[XLEN-3:0], 2'b00};
    jmp_target = {in_pc[XLEN-1:28], in_instr[25:0], 2'b00};
  end

  // Branch condition on forwarded operands, signed compares
  always_comb begin
    case (br_t'(in_br))
      BR_EQ:   br_taken = (rd1 == rd2);
      BR_NE:   br_taken = (rd1 != rd2);
      BR_LEZ:  br_taken = ($signed(rd1) <= 0);
      BR_GTZ:  br_taken = ($signed(rd1) > 0);
      BR_LTZ:  br_taken = ($signed(rd1) < 0);
      BR_GEZ:  br_taken = ($signed(rd1) >= 0);
      default: br_taken = 1'b0;
    endcase
    redirect_valid = fire && (br_taken || in_jmp || in_jr);
    if (in_jr)       redirect_pc = rd1;
    else if (in_jmp) redirect_pc = jmp_target;
    else             redirect_pc = br_target;
  end

  // Output bundle next state: load on fire, drain on ready, flush clears valid
  always_comb begin
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_ctrl_d  = out_ctrl_q;
    out_rd1_d   = out_rd1_q;
    out_rd2_d   = out_rd2_q;
    out_ext_d   = out_ext_q;
    if (fire) begin
      out_valid_d = 1'b1;
      out_pc_d    = in_pc;
      out_instr_d = in_instr;
      out_ctrl_d  = in_ctrl;
      out_rd1_d   = rd1;
      out_rd2_d   = rd2;
      out_ext_d   = ext;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (flush) out_valid_d = 1'b0;
  end

  // Output bundle register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      out_ctrl_q  <= '0;
      out_rd1_q   <= '0;
      out_rd2_q   <= '0;
      out_ext_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_ctrl_q  <= out_ctrl_d;
      out_rd1_q   <= out_rd1_d;
      out_rd2_q   <= out_rd2_d;
      out_ext_q   <= out_ext_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_instr = out_instr_q;
  assign out_ctrl  = out_ctrl_q;
  assign out_rd1   = out_rd1_q;
  assign out_rd2   = out_rd2_q;
  assign out_ext   = out_ext_q;

endmodule
